// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//   Miss-handling engine that sits between the I-/D-cache arrays and a
//   multi-cycle main memory. On a miss it latches the block-aligned base,
//   streams one read request per cycle for every 16-bit word of the block, and
//   writes each returned word into the cache data array. The tag/valid write is
//   issued together with the last data word. fsm_busy_o stalls the pipeline
//   stage that missed for the whole fill.
//
// Ports
//   clk_i                clock, all state updates on posedge
//   rst_i                synchronous reset, active-high (wins over a miss)
//   miss_detected_i      cache reports a miss this cycle (sampled in IDLE only)
//   miss_address_i       byte address that missed
//   memory_data_i        read data from main memory
//   memory_data_valid_i  memory_data_i valid this cycle (ignored in IDLE)
//   fsm_busy_o           fill in progress, stall pipeline
//   mem_read_en_o        read request to memory this cycle
//   memory_address_o     byte address of the current read request (base when idle)
//   write_data_array_o   write fill_data_o into cache word fill_word_addr_o
//   fill_word_addr_o     byte address of the word written to the cache (base when idle)
//   fill_data_o          pass-through of memory_data_i
//   write_tag_array_o    write tag/valid for fill_tag_o's block (one cycle per fill)
//   fill_tag_o           tag of the block being filled (upper bits of base)
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter  int ADDR_W      = 16,
  parameter  int BLOCK_WORDS = 8,
  localparam int OFF_W       = $clog2(2 * BLOCK_WORDS),
  localparam int CNT_W       = $clog2(BLOCK_WORDS) + 1,
  localparam int TAG_W       = ADDR_W - OFF_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              miss_detected_i,
  input  logic [ADDR_W-1:0] miss_address_i,
  input  logic [15:0]       memory_data_i,
  input  logic              memory_data_valid_i,
  output logic              fsm_busy_o,
  output logic              mem_read_en_o,
  output logic [ADDR_W-1:0] memory_address_o,
  output logic              write_data_array_o,
  output logic [ADDR_W-1:0] fill_word_addr_o,
  output logic [15:0]       fill_data_o,
  output logic              write_tag_array_o,
  output logic [TAG_W-1:0]  fill_tag_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] BLK_MASK = {{TAG_W{1'b1}}, {OFF_W{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;

  logic              in_fill;
  logic              issue;
  logic              recv;
  logic              last_word;
  logic [ADDR_W-1:0] issue_off;
  logic [ADDR_W-1:0] rx_off;

  // ---------------------------------------------------------------------------
  // Datapath strobes. Issue and receive are independent streams; the receive
  // counter guard keeps a stray valid after the last word from advancing it.
  // ---------------------------------------------------------------------------
  assign in_fill   = (state_q == S_FILL);
  assign issue     = in_fill && (issue_cnt_q < CNT_FULL);
  assign recv      = in_fill && memory_data_valid_i && (rx_cnt_q < CNT_FULL);
  assign last_word = recv && (rx_cnt_q == CNT_LAST);

  // Word index -> byte offset. base is block-aligned and offsets stay inside
  // the block, so the add can never carry into the tag bits.
  assign issue_off = ADDR_W'({issue_cnt_q[CNT_W-2:0], 1'b0});
  assign rx_off    = ADDR_W'({rx_cnt_q[CNT_W-2:0], 1'b0});

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_detected_i) begin
          base_d      = miss_address_i & BLK_MASK;
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        // miss_detected_i is deliberately not looked at here: base must stay
        // put so the tag and word addresses stay consistent for the whole fill.
        if (issue) issue_cnt_d = issue_cnt_q + CNT_ONE;
        if (recv)  rx_cnt_d    = rx_cnt_q + CNT_ONE;
        if (last_word) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset has priority over an incoming miss.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. These are combinational from state/counters/memory inputs so that
  // the data write lands in the same cycle the memory word is presented; the
  // memory does not hold its data for a second cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_busy_o         = in_fill;
    mem_read_en_o      = issue;
    memory_address_o   = base_q;
    write_data_array_o = recv;
    fill_word_addr_o   = base_q;
    write_tag_array_o  = last_word;
    if (issue) memory_address_o = base_q + issue_off;
    if (recv)  fill_word_addr_o = base_q + rx_off;
  end

  assign fill_data_o = memory_data_i;
  assign fill_tag_o  = base_q[ADDR_W-1:OFF_W];

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;
  localparam int ADDR_W = 16;
  localparam int BW     = 8;
  localparam int TAG_W  = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              miss_detected = 1'b0;
  logic [ADDR_W-1:0] miss_address = '0;
  logic [15:0]       memory_data = '0;
  logic              memory_data_valid = 1'b0;
  logic              fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [ADDR_W-1:0] memory_address, fill_word_addr;
  logic [15:0]       fill_data;
  logic [TAG_W-1:0]  fill_tag;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BW)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .miss_detected_i     (miss_detected),
    .miss_address_i      (miss_address),
    .memory_data_i       (memory_data),
    .memory_data_valid_i (memory_data_valid),
    .fsm_busy_o          (fsm_busy),
    .mem_read_en_o       (mem_read_en),
    .memory_address_o    (memory_address),
    .write_data_array_o  (write_data_array),
    .fill_word_addr_o    (fill_word_addr),
    .fill_data_o         (fill_data),
    .write_tag_array_o   (write_tag_array),
    .fill_tag_o          (fill_tag)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Memory model: requests queue up and return in order after lat cycles.
  typedef struct {
    logic [15:0] addr;
    int          ready;
  } req_t;
  req_t pend[$];
  int   lat      = 4;
  int   gap_mode = 0;   // 0: back-to-back, 1: every 2nd cycle, 2: random gaps
  bit   rand_lat = 1'b0;

  // Reference: a fill is a list of word addresses still to issue and to receive.
  bit          m_busy = 1'b0;
  logic [15:0] m_base = '0;
  logic [15:0] exp_iss[$];
  logic [15:0] exp_rx[$];

  // Counts of DUT strobes, sampled each cycle.
  int busy_cnt = 0, wr_cnt = 0, tag_cnt = 0, rd_cnt = 0;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory response, check outputs at negedge, advance
  // the reference at posedge. Caller sets rst/miss inputs before calling.
  task automatic tick();
    bit          allow, e_rd, e_wr, e_tag;
    logic [15:0] e_maddr, e_faddr;
    memory_data_valid = 1'b0;
    memory_data       = 16'($urandom);
    if (pend.size() > 0 && pend[0].ready <= cyc) begin
      allow = (gap_mode == 0) || (gap_mode == 1 && cyc % 2 == 0) ||
              (gap_mode == 2 && $urandom_range(0, 2) != 0);
      if (allow) begin
        memory_data_valid = 1'b1;
        memory_data       = mdata(pend[0].addr);
      end
    end
    @(negedge clk);
    e_rd    = m_busy && exp_iss.size() > 0;
    e_maddr = e_rd ? exp_iss[0] : m_base;
    e_wr    = m_busy && memory_data_valid && exp_rx.size() > 0;
    e_faddr = e_wr ? exp_rx[0] : m_base;
    e_tag   = e_wr && exp_rx.size() == 1;
    chk("busy",       32'(fsm_busy),         32'(m_busy));
    chk("read_en",    32'(mem_read_en),      32'(e_rd));
    chk("mem_addr",   32'(memory_address),   32'(e_maddr));
    chk("write_data", 32'(write_data_array), 32'(e_wr));
    chk("fill_addr",  32'(fill_word_addr),   32'(e_faddr));
    chk("fill_data",  32'(fill_data),        32'(memory_data));
    chk("write_tag",  32'(write_tag_array),  32'(e_tag));
    chk("fill_tag",   32'(fill_tag),         32'(m_base[15:4]));
    if (e_wr) chk("data_order", 32'(fill_data), 32'(mdata(exp_rx[0])));
    busy_cnt += int'(fsm_busy);
    wr_cnt   += int'(write_data_array);
    tag_cnt  += int'(write_tag_array);
    rd_cnt   += int'(mem_read_en);
    if (mem_read_en)
      pend.push_back('{addr: memory_address,
                       ready: cyc + (rand_lat ? $urandom_range(1, 7) : lat)});
    @(posedge clk);
    if (memory_data_valid) void'(pend.pop_front());
    if (rst) begin
      m_busy = 1'b0;
      m_base = '0;
      exp_iss.delete();
      exp_rx.delete();
    end else if (!m_busy) begin
      if (miss_detected) begin
        m_base = miss_address & 16'hFFF0;
        for (int k = 0; k < BW; k++) begin
          exp_iss.push_back(16'(m_base + 16'(2 * k)));
          exp_rx.push_back(16'(m_base + 16'(2 * k)));
        end
        m_busy = 1'b1;
      end
    end else begin
      if (e_rd) void'(exp_iss.pop_front());
      if (e_wr) begin
        void'(exp_rx.pop_front());
        if (exp_rx.size() == 0) m_busy = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clr_cnt();
    busy_cnt = 0; wr_cnt = 0; tag_cnt = 0; rd_cnt = 0;
  endtask

  // Tick until the reference is idle and memory has drained, bounded.
  task automatic run_idle(input string tag);
    int n = 0;
    while ((m_busy || pend.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(m_busy || pend.size() > 0), 32'(0));
  endtask

  // Accept a miss then run the whole fill with miss deasserted.
  task automatic fill(input logic [15:0] addr, input string tag);
    miss_detected = 1'b1;
    miss_address  = addr;
    clr_cnt();
    tick();
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);   // must not be re-latched mid fill
    run_idle(tag);
    chk({tag, "_writes"}, 32'(wr_cnt),  32'(BW));
    chk({tag, "_reads"},  32'(rd_cnt),  32'(BW));
    chk({tag, "_tags"},   32'(tag_cnt), 32'(1));
  endtask

  initial begin
    int wr_at_rst;
    int n;
    @(posedge clk); #1;

    // Reset state, with a miss held high at the same time: reset wins.
    rst = 1'b1; miss_detected = 1'b1; miss_address = 16'h1230;
    tick();
    tick();
    chk("rst_busy", 32'(fsm_busy), 32'(0));
    rst = 1'b0; miss_detected = 1'b0;
    tick();

    // 1: aligned fill, standard 4-cycle memory, busy exactly 12 cycles.
    lat = 4; gap_mode = 0;
    fill(16'h1230, "t1");
    chk("t1_busy_len", 32'(busy_cnt), 32'(12));

    // 2: unaligned miss is aligned down to its block.
    fill(16'h1236, "t2");
    chk("t2_busy_len", 32'(busy_cnt), 32'(12));
    chk("t2_tag", 32'(fill_tag), 32'(12'h123));

    // 3: data valid only on every 2nd cycle.
    gap_mode = 1;
    fill(16'h1230, "t3");

    // 4: reset after 3 words; late valids must not write; then a clean fill.
    gap_mode = 0;
    miss_detected = 1'b1; miss_address = 16'h1230;
    clr_cnt();
    tick();
    miss_detected = 1'b0;
    n = 0;
    while (wr_cnt < 3 && n < 50) begin tick(); n++; end
    chk("t4_three_words", 32'(wr_cnt), 32'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_at_rst = wr_cnt;
    chk("t4_busy_after_rst", 32'(fsm_busy), 32'(0));
    run_idle("t4_drain");
    chk("t4_no_late_writes", 32'(wr_cnt), 32'(wr_at_rst));
    chk("t4_no_tag", 32'(tag_cnt), 32'(0));
    fill(16'h4000, "t4b");

    // 5: miss held high through a fill; next fill accepted right after the tag.
    miss_detected = 1'b1; miss_address = 16'h0010;
    clr_cnt();
    tick();
    run_idle("t5a");
    chk("t5_first_tags", 32'(tag_cnt), 32'(1));
    tick();                          // first idle cycle: miss accepted here
    chk("t5_reaccept", 32'(m_busy), 32'(1));
    miss_detected = 1'b0;
    run_idle("t5b");
    chk("t5_total_tags", 32'(tag_cnt), 32'(2));
    chk("t5_total_writes", 32'(wr_cnt), 32'(2 * BW));

    // 6: top-of-space block, no carry out.
    fill(16'hFFF2, "t6");
    chk("t6_tag", 32'(fill_tag), 32'(12'hFFF));

    // 7: random misses/addresses, random latency and gaps.
    gap_mode = 2; rand_lat = 1'b1;
    clr_cnt();
    for (int i = 0; i < 1500; i++) begin
      miss_detected = ($urandom_range(0, 3) == 0);
      miss_address  = 16'($urandom);
      tick();
    end
    miss_detected = 1'b0;
    run_idle("t7");
    chk("t7_tag_per_fill", 32'(wr_cnt), 32'(tag_cnt * BW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
